// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Free-running VGA raster timing generator (800x600 @ 72 Hz from a 50 MHz
// clock by default). Issues the raster coordinate to the renderers, takes
// their colour back PIXEL_LATENCY clocks later, blanks it outside the visible
// area and drives the sync pins with the same delay. Sync and colour therefore
// reach the DAC cycle-aligned.
//
// Ports
//   clk          pixel clock
//   rst_n        asynchronous, active-low reset
//   PIXEL        renderer colour {R,G,B} for the coordinate issued
//                PIXEL_LATENCY clocks earlier
//   PIXEL_H      horizontal count, 0..H_TOTAL-1, also driven during blanking
//   PIXEL_V      vertical count,   0..V_TOTAL-1, also driven during blanking
//   VGA_RGB      blanked colour to the pins
//   VGA_HS       horizontal sync, active level HS_POL
//   VGA_VS       vertical sync, active level VS_POL
//   frame_start  one-clock pulse while PIXEL_H/PIXEL_V read (0,0) after a
//                frame wrap (coordinate domain, not delayed)
//
// Coordinate-to-pin latency is PIXEL_LATENCY+1 clocks.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int   H_VISIBLE     = 800,
    parameter int   H_FRONT       = 56,
    parameter int   H_SYNC        = 120,
    parameter int   H_BACK        = 64,
    parameter int   V_VISIBLE     = 600,
    parameter int   V_FRONT       = 37,
    parameter int   V_SYNC        = 6,
    parameter int   V_BACK        = 23,
    parameter logic HS_POL        = 1'b1,
    parameter logic VS_POL        = 1'b1,
    parameter int   PIXEL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  PIXEL,
    output logic [10:0] PIXEL_H,
    output logic [10:0] PIXEL_V,
    output logic [2:0]  VGA_RGB,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Decode thresholds are 12 bits wide so a sync window that ends exactly
    // at 2048 still compares correctly against the 11-bit counters.
    localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS_END    = 12'(H_VISIBLE);
    localparam logic [11:0] V_VIS_END    = 12'(V_VISIBLE);
    localparam logic [11:0] H_SYNC_START = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] H_SYNC_END   = 12'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [11:0] V_SYNC_START = 12'(V_VISIBLE + V_FRONT);
    localparam logic [11:0] V_SYNC_END   = 12'(V_VISIBLE + V_FRONT + V_SYNC);

    generate
        if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
        end
        if (PIXEL_LATENCY < 0 || PIXEL_LATENCY > 4) begin : g_bad_latency
            $error("vga_timing_gen: PIXEL_LATENCY must be in 0..4");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [10:0] h_reg;
    logic [10:0] v_reg;
    logic [10:0] h_next;
    logic [10:0] v_next;
    logic        h_wrap;
    logic        v_wrap;
    logic        frame_start_reg;

    always_comb begin
        h_wrap = (h_reg == H_LAST);
        v_wrap = (v_reg == V_LAST);
        h_next = h_wrap ? 11'd0 : h_reg + 11'd1;
        v_next = v_reg;
        if (h_wrap) begin
            v_next = v_wrap ? 11'd0 : v_reg + 11'd1;
        end
    end

    // frame_start is registered alongside the counters and only set by a
    // real wrap, so the (0,0) held through reset does not produce a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_reg           <= 11'd0;
            v_reg           <= 11'd0;
            frame_start_reg <= 1'b0;
        end else begin
            h_reg           <= h_next;
            v_reg           <= v_next;
            frame_start_reg <= h_wrap && v_wrap;
        end
    end

    assign PIXEL_H     = h_reg;
    assign PIXEL_V     = v_reg;
    assign frame_start = frame_start_reg;

    // ------------------------------------------------------------------
    // Coordinate decode: {active, hs, vs}, all active-high internally.
    // vs depends on v only, so it can change only when h wraps to 0.
    // ------------------------------------------------------------------
    logic [11:0] h_ext;
    logic [11:0] v_ext;
    logic [2:0]  flags;
    logic [2:0]  flags_d;

    always_comb begin
        h_ext    = {1'b0, h_reg};
        v_ext    = {1'b0, v_reg};
        flags    = 3'b000;
        flags[2] = (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
        flags[1] = (h_ext >= H_SYNC_START) && (h_ext < H_SYNC_END);
        flags[0] = (v_ext >= V_SYNC_START) && (v_ext < V_SYNC_END);
    end

    // ------------------------------------------------------------------
    // Delay line matching the renderer latency. Cleared stages read as
    // "inactive, not sync", so the pins stay blank until the first real
    // coordinate has travelled through.
    // ------------------------------------------------------------------
    generate
        if (PIXEL_LATENCY == 0) begin : g_no_delay
            assign flags_d = flags;
        end else begin : g_delay
            logic [2:0] dly_reg [PIXEL_LATENCY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIXEL_LATENCY; i++) begin
                        dly_reg[i] <= 3'b000;
                    end
                end else begin
                    dly_reg[0] <= flags;
                    for (int i = 1; i < PIXEL_LATENCY; i++) begin
                        dly_reg[i] <= dly_reg[i-1];
                    end
                end
            end

            assign flags_d = dly_reg[PIXEL_LATENCY-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register: colour and syncs leave on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            VGA_RGB <= 3'b000;
            VGA_HS  <= ~HS_POL;
            VGA_VS  <= ~VS_POL;
        end else begin
            VGA_RGB <= flags_d[2] ? PIXEL : 3'b000;
            VGA_HS  <= flags_d[1] ? HS_POL : ~HS_POL;
            VGA_VS  <= flags_d[0] ? VS_POL : ~VS_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Three instances share clk/rst_n:
//   u0: default 800x600 geometry, PIXEL_LATENCY = 1
//   u1: reduced 30x17 raster,     PIXEL_LATENCY = 2
//   u2: reduced 30x17 raster,     PIXEL_LATENCY = 0, active-low syncs
// The reduced rasters keep whole-frame scenarios short. One instance is
// modelled at a time: expected pin values are pushed to a queue when the
// coordinate is issued and popped as the pins produce them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_gen;

    localparam int N = 3;
    localparam int HV  [N] = '{800, 16, 16};
    localparam int HF  [N] = '{56,  4,  4};
    localparam int HSW [N] = '{120, 6,  6};
    localparam int HB  [N] = '{64,  4,  4};
    localparam int VV  [N] = '{600, 10, 10};
    localparam int VF  [N] = '{37,  2,  2};
    localparam int VSW [N] = '{6,   3,  3};
    localparam int VB  [N] = '{23,  2,  2};
    localparam int LAT [N] = '{1,   2,  0};
    localparam bit HP  [N] = '{1'b1, 1'b1, 1'b0};
    localparam bit VP  [N] = '{1'b1, 1'b1, 1'b0};

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  pixel [N];
    logic [10:0] ph    [N];
    logic [10:0] pv    [N];
    logic [2:0]  rgb   [N];
    logic        hso   [N];
    logic        vso   [N];
    logic        fso   [N];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        vga_timing_gen #(
            .H_VISIBLE(HV[gi]), .H_FRONT(HF[gi]), .H_SYNC(HSW[gi]), .H_BACK(HB[gi]),
            .V_VISIBLE(VV[gi]), .V_FRONT(VF[gi]), .V_SYNC(VSW[gi]), .V_BACK(VB[gi]),
            .HS_POL(HP[gi]), .VS_POL(VP[gi]), .PIXEL_LATENCY(LAT[gi])
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .PIXEL(pixel[gi]),
            .PIXEL_H(ph[gi]), .PIXEL_V(pv[gi]), .VGA_RGB(rgb[gi]),
            .VGA_HS(hso[gi]), .VGA_VS(vso[gi]), .frame_start(fso[gi])
        );
    end

    int errors = 0;
    int checks = 0;

    // ------------------------------------------------------------------
    // Reference model and scoreboard for instance 'cur'
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
    } pins_t;

    pins_t      exp_q [$];
    logic [2:0] px_q  [$];
    pins_t      exp_now;
    int         cur = 0;
    int         lat = 0;
    int         pxmode = 0;   // 0: constant 7, 1: h[2:0], 2: random
    int         mh = 0;
    int         mv = 0;
    logic       mfs = 1'b0;

    function automatic int htot(int i);
        return HV[i] + HF[i] + HSW[i] + HB[i];
    endfunction

    function automatic int vtot(int i);
        return VV[i] + VF[i] + VSW[i] + VB[i];
    endfunction

    function automatic pins_t inactive_pins();
        pins_t p;
        p.rgb = 3'b000;
        p.hs  = ~HP[cur];
        p.vs  = ~VP[cur];
        return p;
    endfunction

    function automatic logic [27:0] obs(int i);
        return {ph[i], pv[i], fso[i], rgb[i], hso[i], vso[i]};
    endfunction

    function automatic logic [27:0] rstv(int i);
        return {22'd0, 1'b0, 3'b000, ~HP[i], ~VP[i]};
    endfunction

    function automatic logic [27:0] expv();
        return {11'(mh), 11'(mv), mfs, exp_now.rgb, exp_now.hs, exp_now.vs};
    endfunction

    // Issue the model's current coordinate: choose the renderer colour for
    // it and queue the pin values it must eventually produce.
    task automatic push_coord();
        logic [2:0] px;
        pins_t      e;
        logic       act, hsa, vsa;
        case (pxmode)
            0:       px = 3'b111;
            1:       px = 3'(mh);
            default: px = 3'($urandom_range(0, 7));
        endcase
        act = (mh < HV[cur]) && (mv < VV[cur]);
        hsa = (mh >= HV[cur] + HF[cur]) && (mh < HV[cur] + HF[cur] + HSW[cur]);
        vsa = (mv >= VV[cur] + VF[cur]) && (mv < VV[cur] + VF[cur] + VSW[cur]);
        e.rgb = act ? px : 3'b000;
        e.hs  = hsa ? HP[cur] : ~HP[cur];
        e.vs  = vsa ? VP[cur] : ~VP[cur];
        exp_q.push_back(e);
        px_q.push_back(px);
    endtask

    // Model state at reset release: (0,0) is the first coordinate, preceded
    // by 'lat' blank pipeline slots.
    task automatic model_release();
        mh  = 0;
        mv  = 0;
        mfs = 1'b0;
        exp_q.delete();
        px_q.delete();
        for (int s = 0; s < lat; s++) begin
            exp_q.push_back(inactive_pins());
            px_q.push_back(3'($urandom_range(0, 7)));
        end
        push_coord();
        pixel[cur] = px_q[0];
    endtask

    // One clock of the model; exp_now receives the pins due this cycle.
    task automatic model_step();
        mh = mh + 1;
        if (mh == htot(cur)) begin
            mh = 0;
            mv = mv + 1;
            if (mv == vtot(cur)) mv = 0;
        end
        mfs = (mh == 0) && (mv == 0);
        exp_now = exp_q.pop_front();
        void'(px_q.pop_front());
        push_coord();
        pixel[cur] = px_q[0];
    endtask

    task automatic hold_reset(int n);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        model_release();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        cur = 0; lat = LAT[0]; pxmode = 2;
        @(negedge clk);
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < N; i++) pixel[i] = 3'($urandom_range(0, 7));
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                checks++;
                if (obs(i) !== rstv(i)) begin
                    errors++;
                    $display("FAIL reset c%0d u%0d: got %h expected %h", c, i, obs(i), rstv(i));
                end
            end
        end
        release_reset();
    endtask

    task automatic test_line_timing();
        int   rises [$];
        int   falls [$];
        int   t856 = -1;
        logic prev = 1'b0;
        for (int k = 1; k <= 4 * 1040; k++) begin
            @(negedge clk);
            model_step();
            checks++;
            if (obs(0) !== expv()) begin
                errors++;
                $display("FAIL line_sb k%0d: got %h expected %h", k, obs(0), expv());
            end
            if (ph[0] == 11'd856 && pv[0] == 11'd0 && t856 < 0) t856 = k;
            if (hso[0] && !prev) rises.push_back(k);
            if (!hso[0] && prev) falls.push_back(k);
            prev = hso[0];
        end
        checks++;
        if (rises.size() != 4) begin
            errors++;
            $display("FAIL hs_rise_count: got %0d expected 4", rises.size());
        end
        for (int j = 1; j < rises.size(); j++) begin
            checks++;
            if (rises[j] - rises[j-1] != 1040) begin
                errors++;
                $display("FAIL hs_period %0d: got %0d expected 1040", j, rises[j] - rises[j-1]);
            end
        end
        for (int j = 0; j < falls.size() && j < rises.size(); j++) begin
            checks++;
            if (falls[j] - rises[j] != 120) begin
                errors++;
                $display("FAIL hs_width %0d: got %0d expected 120", j, falls[j] - rises[j]);
            end
        end
        checks++;
        if (rises.size() == 0 || t856 < 0 || rises[0] - t856 != 2) begin
            errors++;
            $display("FAIL hs_first_edge: rise %0d h856 at %0d expected offset 2",
                     (rises.size() > 0) ? rises[0] : -1, t856);
        end
    endtask

    task automatic test_blanking();
        int lit = 0;
        int maxv = 0;
        cur = 1; lat = LAT[1]; pxmode = 0;
        hold_reset(2);
        release_reset();
        for (int k = 1; k <= 1022; k++) begin
            @(negedge clk);
            model_step();
            checks++;
            if (obs(1) !== expv()) begin
                errors++;
                $display("FAIL blank_sb k%0d: got %h expected %h", k, obs(1), expv());
            end
            if (k >= 3 && rgb[1] === 3'b111) lit++;
            if (int'(pv[1]) > maxv) maxv = int'(pv[1]);
        end
        checks++;
        if (lit != 320) begin
            errors++;
            $display("FAIL blank_lit_count: got %0d expected 320", lit);
        end
        checks++;
        if (maxv != 16) begin
            errors++;
            $display("FAIL max_pixel_v: got %0d expected 16", maxv);
        end
    endtask

    task automatic test_frame_timing();
        int   fs_t [$];
        int   vr [$];
        int   vf [$];
        int   t360 = -1;
        logic prev = 1'b0;
        logic act;
        cur = 1; lat = LAT[1]; pxmode = 2;
        hold_reset(2);
        release_reset();
        for (int k = 1; k <= 1630; k++) begin
            @(negedge clk);
            model_step();
            checks++;
            if (obs(1) !== expv()) begin
                errors++;
                $display("FAIL frame_sb k%0d: got %h expected %h", k, obs(1), expv());
            end
            if (fso[1] === 1'b1) fs_t.push_back(k);
            if (ph[1] == 11'd0 && pv[1] == 11'd12 && t360 < 0) t360 = k;
            act = (vso[1] === VP[1]);
            if (act && !prev) vr.push_back(k);
            if (!act && prev) vf.push_back(k);
            prev = act;
        end
        checks++;
        if (fs_t.size() != 3 || fs_t[0] != 510) begin
            errors++;
            $display("FAIL frame_start_first: got %0d pulses first at %0d expected 3 first at 510",
                     fs_t.size(), (fs_t.size() > 0) ? fs_t[0] : -1);
        end
        for (int j = 1; j < fs_t.size(); j++) begin
            checks++;
            if (fs_t[j] - fs_t[j-1] != 510) begin
                errors++;
                $display("FAIL frame_period %0d: got %0d expected 510", j, fs_t[j] - fs_t[j-1]);
            end
        end
        checks++;
        if (vr.size() != 3 || t360 < 0 || vr[0] - t360 != 3) begin
            errors++;
            $display("FAIL vs_first_edge: %0d rises, first %0d, v12 at %0d expected offset 3",
                     vr.size(), (vr.size() > 0) ? vr[0] : -1, t360);
        end
        for (int j = 0; j < vf.size() && j < vr.size(); j++) begin
            checks++;
            if (vf[j] - vr[j] != 90) begin
                errors++;
                $display("FAIL vs_width %0d: got %0d expected 90", j, vf[j] - vr[j]);
            end
        end
    endtask

    task automatic test_latency(int idx);
        int         hq [$];
        int         vq [$];
        int         h0, v0;
        logic [2:0] want;
        cur = idx; lat = LAT[idx]; pxmode = 1;
        hold_reset(2);
        release_reset();
        hq.push_back(0);
        vq.push_back(0);
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            model_step();
            hq.push_back(mh);
            vq.push_back(mv);
            want = 3'b000;
            if (hq.size() == lat + 2) begin
                h0 = hq.pop_front();
                v0 = vq.pop_front();
                if (h0 < HV[idx] && v0 < VV[idx]) want = 3'(h0);
            end
            checks++;
            if (rgb[idx] !== want) begin
                errors++;
                $display("FAIL latency_rgb u%0d k%0d: got %0d expected %0d", idx, k, rgb[idx], want);
            end
            checks++;
            if (obs(idx) !== expv()) begin
                errors++;
                $display("FAIL latency_sb u%0d k%0d: got %h expected %h", idx, k, obs(idx), expv());
            end
        end
    endtask

    task automatic test_mid_reset();
        bit found = 1'b0;
        int t_fs = -1;
        cur = 2; lat = LAT[2]; pxmode = 2;
        hold_reset(2);
        release_reset();
        for (int k = 1; k <= 600 && !found; k++) begin
            @(negedge clk);
            model_step();
            checks++;
            if (obs(2) !== expv()) begin
                errors++;
                $display("FAIL mid_pre_sb k%0d: got %h expected %h", k, obs(2), expv());
            end
            if (mh == 22 && mv == 5) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_reach: coordinate (22,5) got not reached expected reached");
        end
        // Assert reset between edges while HS is on the pins.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs(2) !== rstv(2)) begin
            errors++;
            $display("FAIL mid_async: got %h expected %h", obs(2), rstv(2));
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (obs(2) !== rstv(2)) begin
                errors++;
                $display("FAIL mid_hold c%0d: got %h expected %h", c, obs(2), rstv(2));
            end
        end
        release_reset();
        for (int k = 1; k <= 600 && t_fs < 0; k++) begin
            @(negedge clk);
            model_step();
            checks++;
            if (obs(2) !== expv()) begin
                errors++;
                $display("FAIL mid_post_sb k%0d: got %h expected %h", k, obs(2), expv());
            end
            if (fso[2] === 1'b1) t_fs = k;
        end
        checks++;
        if (t_fs != 510) begin
            errors++;
            $display("FAIL mid_frame_start: got %0d expected 510", t_fs);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) pixel[i] = 3'b000;
        test_reset();
        test_line_timing();
        test_blanking();
        test_frame_timing();
        test_latency(1);
        test_latency(2);
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
